lap_stopwatch: RTL

Parametrised stopwatch with start/stop/pause control, a tick prescaler, a selectable wrap or saturate overflow mode, and a lap-capture FIFO read through a valid/ready handshake. It is the general-purpose timing block for lab designs: `time_o` drives display logic, and the lap port is drained by a consumer such as a UART or display sequencer.

---
 rtl/stopwatch_pkg.sv | 17 +
 rtl/lap_fifo.sv | 57 +++++
 rtl/lap_stopwatch.sv | 139 +++++++++++++
 3 files changed

// File: rtl/stopwatch_pkg.sv
// Shared types and helpers for the stopwatch family of blocks.
// No logic: state encoding and width helpers only.
// Imported by lap_stopwatch and any later block reusing its FSM states.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUNNING = 2'd1,
        PAUSED  = 2'd2
    } sw_state_t;

    // Occupancy counters need one more bit than the address so "full" is representable.
    function automatic int lap_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/lap_fifo.sv
// Purpose: synchronous first-word-fall-through FIFO for lap timestamps.
// Latency: a push is visible on head_o/valid_o right after its clock edge.
// Backpressure: pushes while full are refused unless a pop frees a slot the same cycle.
module lap_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     clear_i,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic                     valid_o,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o
);

    localparam int AW = $clog2(DEPTH);

    // Pointers carry an extra MSB so equal addresses can be told apart as empty or full.
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             pop_ok;
    logic             push_ok;

    assign count_o = wr_ptr - rd_ptr;
    assign valid_o = (count_o != '0);
    assign full_o  = (count_o == (AW+1)'(DEPTH));
    assign pop_ok  = pop_i && valid_o;
    // When full, a same-cycle pop frees the slot the write lands in.
    assign push_ok = push_i && (!full_o || pop_ok);
    // Head reads zero when empty so stale entries never leak onto the port.
    assign head_o  = valid_o ? mem[rd_ptr[AW-1:0]] : '0;

    // Pointer bookkeeping; clear flushes by collapsing both pointers.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (clear_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    // Storage array; contents are only observable through valid entries, so no reset.
    always_ff @(posedge clk_i) begin
        if (push_ok && !clear_i) mem[wr_ptr[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/lap_stopwatch.sv
// Purpose: start/stop/pause stopwatch with prescaler, wrap/saturate overflow and lap FIFO.
// Latency: all outputs registered; first count P edges after RUNNING is entered.
// Backpressure: lap FIFO drained via lap_valid_o/lap_ready_i; laps into a full FIFO are dropped and flagged.
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int PRESCALE  = 1,
    parameter int LAP_DEPTH = 4,
    parameter int WRAP      = 1
) (
    input  logic                                  clk_i,
    input  logic                                  reset_i,
    input  logic                                  start_i,
    input  logic                                  stop_i,
    input  logic                                  clear_i,
    input  logic                                  lap_i,
    input  logic                                  lap_ready_i,
    output logic [WIDTH-1:0]                      time_o,
    output logic                                  running_o,
    output logic                                  overflow_o,
    output logic                                  lap_valid_o,
    output logic [WIDTH-1:0]                      lap_time_o,
    output logic [lap_cnt_width(LAP_DEPTH)-1:0]   lap_count_o,
    output logic                                  lap_drop_o
);

    localparam int              PW        = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0]   PRESC_MAX = PW'(PRESCALE - 1);
    localparam logic [WIDTH-1:0] TIME_MAX = '1;

    sw_state_t        state_q;
    sw_state_t        state_d;
    logic [PW-1:0]    presc_q;
    logic [WIDTH-1:0] time_q;
    logic             running_q;
    logic             overflow_q;
    logic             drop_q;
    logic             tick;
    logic             lap_push;
    logic             lap_pop;
    logic             fifo_full;

    // A tick is the prescaler's last phase while RUNNING; a stop on that edge still lets it land.
    assign tick     = (state_q == RUNNING) && (presc_q == PRESC_MAX);
    // Laps sample the registered time; clear and IDLE suppress them.
    assign lap_push = lap_i && !clear_i && (state_q != IDLE);
    assign lap_pop  = lap_ready_i && !clear_i;

    // Next-state: clear beats stop beats start; unlisted combinations hold.
    always_comb begin
        state_d = state_q;
        if (clear_i) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE:    if (start_i && !stop_i) state_d = RUNNING;
                RUNNING: if (stop_i)             state_d = PAUSED;
                PAUSED:  if (start_i && !stop_i) state_d = RUNNING;
                default: state_d = IDLE;
            endcase
        end
    end

    // State register plus a registered copy of the RUNNING decode.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q   <= IDLE;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            running_q <= (state_d == RUNNING);
        end
    end

    // Prescaler advances only in RUNNING, keeps its phase across a pause, restarts from IDLE.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            presc_q <= '0;
        end else if (clear_i) begin
            presc_q <= '0;
        end else if (state_q == RUNNING) begin
            presc_q <= tick ? '0 : presc_q + 1'b1;
        end else if ((state_q == IDLE) && (state_d == RUNNING)) begin
            presc_q <= '0;
        end
    end

    // Time counter with sticky overflow; the top value either wraps to zero or sticks.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            time_q     <= '0;
            overflow_q <= 1'b0;
        end else if (clear_i) begin
            time_q     <= '0;
            overflow_q <= 1'b0;
        end else if (tick) begin
            if (time_q == TIME_MAX) begin
                overflow_q <= 1'b1;
                if (WRAP != 0) time_q <= '0;
            end else begin
                time_q <= time_q + 1'b1;
            end
        end
    end

    // Sticky drop flag: a lap arrived while full and nothing left the FIFO that cycle.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            drop_q <= 1'b0;
        end else if (clear_i) begin
            drop_q <= 1'b0;
        end else if (lap_push && fifo_full && !(lap_pop && lap_valid_o)) begin
            drop_q <= 1'b1;
        end
    end

    lap_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .clear_i (clear_i),
        .push_i  (lap_push),
        .data_i  (time_q),
        .pop_i   (lap_pop),
        .valid_o (lap_valid_o),
        .head_o  (lap_time_o),
        .count_o (lap_count_o),
        .full_o  (fifo_full)
    );

    assign time_o     = time_q;
    assign running_o  = running_q;
    assign overflow_o = overflow_q;
    assign lap_drop_o = drop_q;

endmodule
